lzd_norm_pipe: RTL and testbench

Pipelined leading-zero/leading-one detector with count encoding and optional normalisation shift. It is the streaming successor of the combinational leading-zero detector and is intended for floating-point normalisation and priority datapaths. It adds a valid/ready handshake, a selectable detection polarity, a binary count, an all-zero/all-one flag and a two-stage elastic pipeline. The prefix-AND structure is selected by the SPEED parameter, as in the rest of the arithmetic library.

---
 rtl/lzd_norm_pipe.sv | 199 +++++++++++++++++++
 tb/tb_lzd_norm_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_norm_pipe.sv
// Two-stage elastic leading-zero/leading-one detector with count, all-match flag and optional normalisation shift.
// Optional normalisation shifter enabled by defining LZD_PIPE_NORM_EN; otherwise out_norm_o is tied to zero.
module lzd_norm_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPEED = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [WIDTH-1:0]                 in_data_i,
    input  logic                             in_mode_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [WIDTH-1:0]                 out_onehot_o,
    output logic [$clog2(WIDTH+1)-1:0]       out_count_o,
    output logic                             out_zero_o,
    output logic [WIDTH-1:0]                 out_norm_o
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic             s1_valid;
    logic             s2_valid;
    logic             s2_ready;
    logic             in_fire;
    logic             move;

    logic [WIDTH-1:0] match;
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] onehot;
    logic [CNT_W-1:0] count;
    logic             zero;

    logic [WIDTH-1:0] s1_onehot;
    logic [CNT_W-1:0] s1_count;
    logic             s1_zero;

    // A set bit in rev marks a leading-polarity bit; rev[0] is the operand MSB.
    assign match = in_mode_i ? in_data_i : ~in_data_i;

    always_comb begin
        rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rev[i] = match[int'(WIDTH) - 1 - i];
        end
    end

    // pre[i] = AND of rev[0..i]
    if (SPEED == 1) begin : g_brent_kung
        always_comb begin
            int src;
            pre = rev;
            src = 0;
            for (int k = 0; k < int'(LEVELS); k++) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    src = (i >= (1 << k)) ? i - (1 << k) : 0;
                    if (((i + 1) % (2 << k)) == 0) begin
                        pre[i] = pre[i] & pre[src];
                    end
                end
            end
            for (int k = int'(LEVELS) - 1; k >= 0; k--) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    src = (i >= (1 << k)) ? i - (1 << k) : 0;
                    if ((((i + 1) % (2 << k)) == (1 << k)) && ((i + 1) > (2 << k))) begin
                        pre[i] = pre[i] & pre[src];
                    end
                end
            end
        end
    end else if (SPEED == 2) begin : g_sklansky
        logic [WIDTH-1:0] stage;
        always_comb begin
            int src;
            pre   = rev;
            stage = rev;
            src   = 0;
            for (int k = 0; k < int'(LEVELS); k++) begin
                stage = pre;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    src = (i >> k) << k;
                    if (src > 0) begin
                        src = src - 1;
                    end
                    if (((i >> k) & 1) == 1) begin
                        pre[i] = stage[i] & stage[src];
                    end
                end
            end
        end
    end else begin : g_serial
        always_comb begin
            logic acc;
            pre = '0;
            acc = 1'b1;
            for (int i = 0; i < int'(WIDTH); i++) begin
                acc    = acc & rev[i];
                pre[i] = acc;
            end
        end
    end

    // First non-matching bit, its MSB-relative position as the count, and the all-match flag.
    always_comb begin
        logic prev;
        first  = '0;
        onehot = '0;
        count  = '0;
        prev   = 1'b1;
        for (int j = 0; j < int'(WIDTH); j++) begin
            first[j] = prev & ~rev[j];
            prev     = pre[j];
        end
        for (int j = 0; j < int'(WIDTH); j++) begin
            onehot[int'(WIDTH) - 1 - j] = first[j];
            if (first[j]) begin
                count = count | CNT_W'(j);
            end
        end
        zero = pre[WIDTH-1];
        if (zero) begin
            count = CNT_W'(WIDTH);
        end
    end

    assign s2_ready   = ~s2_valid | out_ready_i;
    assign in_ready_o = ~s1_valid | s2_ready;
    assign in_fire    = in_valid_i & in_ready_o;
    assign move       = s1_valid & s2_ready;

    // Stage 1: detection results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_onehot <= '0;
            s1_count  <= '0;
            s1_zero   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_onehot <= onehot;
                s1_count  <= count;
                s1_zero   <= zero;
            end else if (move) begin
                s1_valid  <= 1'b0;
            end
        end
    end

    // Stage 2: presented results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid     <= 1'b0;
            out_onehot_o <= '0;
            out_count_o  <= '0;
            out_zero_o   <= 1'b0;
        end else begin
            if (move) begin
                s2_valid     <= 1'b1;
                out_onehot_o <= s1_onehot;
                out_count_o  <= s1_count;
                out_zero_o   <= s1_zero;
            end else if (out_ready_i) begin
                s2_valid     <= 1'b0;
            end
        end
    end

    assign out_valid_o = s2_valid;

`ifdef LZD_PIPE_NORM_EN
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s2_norm;

    // The shift uses the original operand in both modes; a count of WIDTH shifts everything out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_data <= '0;
            s2_norm <= '0;
        end else begin
            if (in_fire) begin
                s1_data <= in_data_i;
            end
            if (move) begin
                s2_norm <= s1_data << s1_count;
            end
        end
    end

    assign out_norm_o = s2_norm;
`else
    assign out_norm_o = '0;
`endif

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: three instances (serial, Brent-Kung, Sklansky) driven in lockstep
// and checked against a queue-based behavioural model.
module tb_lzd_norm_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned ND = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_mode;
    logic          out_ready;

    logic          rdy    [ND];
    logic          ovalid [ND];
    logic [W-1:0]  onehot [ND];
    logic [CW-1:0] count  [ND];
    logic          zero   [ND];
    logic [W-1:0]  norm   [ND];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [W-1:0] onehot;
        int           count;
        bit           zero;
        logic [W-1:0] norm;
        int           acc;
    } exp_t;

    exp_t q[$];

    for (genvar g = 0; g < int'(ND); g++) begin : g_dut
        lzd_norm_pipe #(.WIDTH(W), .SPEED(g)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .in_valid_i   (in_valid),
            .in_ready_o   (rdy[g]),
            .in_data_i    (in_data),
            .in_mode_i    (in_mode),
            .out_valid_o  (ovalid[g]),
            .out_ready_i  (out_ready),
            .out_onehot_o (onehot[g]),
            .out_count_o  (count[g]),
            .out_zero_o   (zero[g]),
            .out_norm_o   (norm[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, idx, act, expv);
        end
    endtask

    // Leading-run length counted directly from the MSB.
    function automatic exp_t model(input logic [W-1:0] d, input logic m);
        exp_t e;
        int   c;
        bit   run;
        c   = 0;
        run = 1'b1;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (run && (d[i] == m)) c++;
            else run = 1'b0;
        end
        e.count  = c;
        e.zero   = (c == int'(W));
        e.onehot = (c == int'(W)) ? 8'h00 : W'(1 << (int'(W) - 1 - c));
`ifdef LZD_PIPE_NORM_EN
        e.norm   = (c == int'(W)) ? 8'h00 : W'(d << c);
`else
        e.norm   = 8'h00;
`endif
        e.acc    = 0;
        return e;
    endfunction

    function automatic bit model_valid();
        return (q.size() > 0) && (cyc > q[0].acc);
    endfunction

    function automatic bit model_ready(input bit ordy);
        return (q.size() < 2) || ordy;
    endfunction

    task automatic check_outputs();
        bit mv;
        mv = model_valid();
        for (int g = 0; g < int'(ND); g++) begin
            chk("out_valid", g, int'(ovalid[g]), int'(mv));
            if (mv) begin
                chk("out_onehot", g, int'(onehot[g]), int'(q[0].onehot));
                chk("out_count",  g, int'(count[g]),  q[0].count);
                chk("out_zero",   g, int'(zero[g]),   int'(q[0].zero));
                chk("out_norm",   g, int'(norm[g]),   int'(q[0].norm));
            end
        end
    endtask

    // Hand-computed expectations; norm_lit applies only when the shifter is built.
    task automatic check_lit(input string name, input bit v, input int oh, input int c,
                             input bit z, input int norm_lit);
        int nexp;
`ifdef LZD_PIPE_NORM_EN
        nexp = norm_lit;
`else
        nexp = 0;
`endif
        for (int g = 0; g < int'(ND); g++) begin
            chk({name, "_valid"}, g, int'(ovalid[g]), int'(v));
            if (v) begin
                chk({name, "_onehot"}, g, int'(onehot[g]), oh);
                chk({name, "_count"},  g, int'(count[g]),  c);
                chk({name, "_zero"},   g, int'(zero[g]),   int'(z));
                chk({name, "_norm"},   g, int'(norm[g]),   nexp);
            end
        end
    endtask

    // One clock: drive, check ready, clock, update model, check outputs.
    task automatic step(input bit v, input logic [W-1:0] d, input bit m, input bit ordy,
                        output bit accepted);
        bit   mv;
        bit   mr;
        bit   ofire;
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        #1;
        mv = model_valid();
        mr = model_ready(ordy);
        for (int g = 0; g < int'(ND); g++) begin
            chk("in_ready", g, int'(rdy[g]), int'(mr));
        end
        accepted = v && mr && rst_n;
        ofire    = mv && ordy && rst_n;
        @(posedge clk);
        cyc++;
        if (ofire) void'(q.pop_front());
        if (accepted) begin
            e     = model(d, m);
            e.acc = cyc;
            q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bit           a;
        int           n;
        int           guard;
        logic [W-1:0] d;
        bit           m;
        logic [W-1:0] bnd [6];

        bnd[0] = 8'h00; bnd[1] = 8'hFF; bnd[2] = 8'h80;
        bnd[3] = 8'h7F; bnd[4] = 8'h01; bnd[5] = 8'hFE;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        #2;
        check_lit("reset", 1'b0, 0, 0, 1'b0, 0);
        for (int g = 0; g < int'(ND); g++) begin
            chk("reset_onehot", g, int'(onehot[g]), 0);
            chk("reset_count",  g, int'(count[g]),  0);
            chk("reset_zero",   g, int'(zero[g]),   0);
            chk("reset_norm",   g, int'(norm[g]),   0);
            chk("reset_ready",  g, int'(rdy[g]),    1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed operands, full throughput
        step(1'b1, 8'h16, 1'b0, 1'b1, a);
        check_lit("lat1", 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 8'hE5, 1'b1, 1'b1, a);
        check_lit("m0_16", 1'b1, 'h10, 3, 1'b0, 'hB0);
        step(1'b1, 8'h00, 1'b0, 1'b1, a);
        check_lit("m1_e5", 1'b1, 'h10, 3, 1'b0, 'h28);
        step(1'b1, 8'hFF, 1'b1, 1'b1, a);
        check_lit("m0_00", 1'b1, 'h00, 8, 1'b1, 'h00);
        step(1'b1, 8'h80, 1'b0, 1'b1, a);
        check_lit("m1_ff", 1'b1, 'h00, 8, 1'b1, 'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        check_lit("m0_80", 1'b1, 'h80, 0, 1'b0, 'h80);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        check_lit("drained", 1'b0, 0, 0, 1'b0, 0);

        // Backpressure: two accepted, then ready falls and count 7 holds
        step(1'b1, 8'h01, 1'b0, 1'b0, a);
        step(1'b1, 8'h02, 1'b0, 1'b0, a);
        check_lit("bp_hold0", 1'b1, 'h01, 7, 1'b0, 'h80);
        for (int s = 0; s < 2; s++) begin
            step(1'b1, 8'h04, 1'b0, 1'b0, a);
            chk("bp_accept_blocked", 0, int'(a), 0);
            for (int g = 0; g < int'(ND); g++) begin
                chk("bp_ready_low", g, int'(rdy[g]), 0);
            end
            check_lit("bp_hold", 1'b1, 'h01, 7, 1'b0, 'h80);
        end
        step(1'b1, 8'h04, 1'b0, 1'b1, a);
        check_lit("bp_rel6", 1'b1, 'h02, 6, 1'b0, 'h80);
        step(1'b1, 8'h08, 1'b0, 1'b1, a);
        check_lit("bp_rel5", 1'b1, 'h04, 5, 1'b0, 'h80);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        check_lit("bp_rel4", 1'b1, 'h08, 4, 1'b0, 'h80);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        check_lit("bp_empty", 1'b0, 0, 0, 1'b0, 0);

        // Reset with both stages full
        step(1'b1, 8'h33, 1'b0, 1'b0, a);
        step(1'b1, 8'h0F, 1'b1, 1'b0, a);
        rst_n = 1'b0;
        #1;
        q.delete();
        for (int g = 0; g < int'(ND); g++) begin
            chk("rst_valid",  g, int'(ovalid[g]), 0);
            chk("rst_onehot", g, int'(onehot[g]), 0);
            chk("rst_count",  g, int'(count[g]),  0);
            chk("rst_zero",   g, int'(zero[g]),   0);
            chk("rst_norm",   g, int'(norm[g]),   0);
            chk("rst_ready",  g, int'(rdy[g]),    1);
        end
        step(1'b1, 8'h99, 1'b0, 1'b1, a);
        rst_n = 1'b1;
        step(1'b1, 8'h40, 1'b0, 1'b1, a);
        check_lit("post_rst_lat", 1'b0, 0, 0, 1'b0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        check_lit("post_rst_40", 1'b1, 'h40, 1, 1'b0, 'h80);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);

        // Random stream: a beat is held until accepted
        n     = 0;
        guard = 0;
        d     = 8'h00;
        m     = 1'b0;
        a     = 1'b1;
        while ((n < 1000) && (guard < 20000)) begin
            if (a) begin
                m = 1'($urandom);
                case ($urandom_range(0, 3))
                    0:       d = bnd[$urandom_range(0, 5)];
                    1:       d = W'(8'($urandom) >> $urandom_range(0, 8));
                    2:       d = ~W'(8'($urandom) >> $urandom_range(0, 8));
                    default: d = W'($urandom);
                endcase
            end
            step(($urandom_range(0, 7) != 0), d, m, ($urandom_range(0, 3) != 0), a);
            if (a) n++;
            guard++;
        end
        chk("stream_complete", 0, n, 1000);

        guard = 0;
        while ((q.size() > 0) && (guard < 20)) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, a);
            guard++;
        end
        chk("drain_empty", 0, int'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
